// File: rtl/keccak_pkg.sv
// Shared Keccak constants and the absorb-side padder state encoding.
package keccak_pkg;

    localparam int KECCAK_W = 1600;
    localparam int LANE_W   = 64;

    localparam logic [7:0] DSEP_SHA3  = 8'h06;
    localparam logic [7:0] DSEP_SHAKE = 8'h1F;

    localparam int R_SHAKE128 = 1344;
    localparam int R_SHA3_256 = 1088;

    typedef enum logic [1:0] {
        ST_ABSORB    = 2'd0,
        ST_PAD       = 2'd1,
        ST_FULL      = 2'd2,
        ST_FULL_LAST = 2'd3
    } padder_state_e;

endpackage

// File: rtl/sponge_padder_pad_word.sv
// Combinational padding of one lane: keeps the valid bytes, inserts the
// domain byte right after them and sets the 0x80 bit when this is the final slot.
module pad_word
    import keccak_pkg::*;
(
    input  logic [LANE_W-1:0] word_i,
    input  logic [3:0]        bytes_i,
    input  logic [7:0]        dsep_i,
    input  logic              finalSlot_i,
    output logic [LANE_W-1:0] padded_o
);

    always_comb begin
        padded_o = '0;
        for (int k = 0; k < LANE_W / 8; k++) begin
            if (4'(k) < bytes_i) begin
                padded_o[8*k +: 8] = word_i[8*k +: 8];
            end else if (4'(k) == bytes_i) begin
                padded_o[8*k +: 8] = dsep_i;
            end
        end
        if (finalSlot_i) begin
            padded_o[LANE_W-1 -: 8] = padded_o[LANE_W-1 -: 8] | 8'h80;
        end
    end

endmodule

// File: rtl/sponge_padder.sv
// Packs 64-bit message words into R-bit rate blocks, applies SHA-3/SHAKE
// padding and hands each block to the permutation through an ack handshake.
module sponge_padder
    import keccak_pkg::*;
#(
    parameter int         R    = R_SHAKE128,
    parameter logic [7:0] DSEP = DSEP_SHAKE
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [63:0]       in,
    input  logic [3:0]        in_bytes,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [R-1:0]      out,
    output logic              out_ready,
    input  logic              f_ack,
    output logic              done
);

    localparam int NW = R / LANE_W;
    localparam int CW = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [CW-1:0] LAST_SLOT = CW'(NW - 1);

    padder_state_e     state_q, state_d;
    logic [CW-1:0]     wordCnt_q, wordCnt_d;
    logic [R-1:0]      buffer_q, buffer_d;
    logic              padPending_q, padPending_d;
    logic              done_q, done_d;

    logic              slotWrite;
    logic              wrPad;
    logic [NW-1:0]     slotWe;
    logic [LANE_W-1:0] padSrc;
    logic [3:0]        padBytes;
    logic [LANE_W-1:0] padWord;

    // The PAD state reuses the same padder with an empty word
    assign padSrc   = (state_q == ST_PAD) ? '0 : in;
    assign padBytes = (state_q == ST_PAD) ? 4'd0 : in_bytes;

    pad_word u_padWord (
        .word_i      (padSrc),
        .bytes_i     (padBytes),
        .dsep_i      (DSEP),
        .finalSlot_i (wordCnt_q == LAST_SLOT),
        .padded_o    (padWord)
    );

    always_comb begin
        state_d      = state_q;
        wordCnt_d    = wordCnt_q;
        buffer_d     = buffer_q;
        padPending_d = padPending_q;
        done_d       = 1'b0;
        slotWrite    = 1'b0;
        wrPad        = 1'b0;
        slotWe       = '0;

        case (state_q)
            ST_ABSORB: begin
                if (in_valid) begin
                    slotWrite = 1'b1;
                    if (in_last && (in_bytes < 4'd8)) begin
                        wrPad   = 1'b1;
                        state_d = ST_FULL_LAST;
                    end else if (wordCnt_q == LAST_SLOT) begin
                        state_d      = ST_FULL;
                        padPending_d = in_last;
                    end else begin
                        wordCnt_d = wordCnt_q + 1'b1;
                        if (in_last) begin
                            state_d = ST_PAD;
                        end
                    end
                end
            end
            ST_PAD: begin
                slotWrite = 1'b1;
                wrPad     = 1'b1;
                state_d   = ST_FULL_LAST;
            end
            ST_FULL: begin
                if (f_ack) begin
                    buffer_d     = '0;
                    wordCnt_d    = '0;
                    padPending_d = 1'b0;
                    state_d      = padPending_q ? ST_PAD : ST_ABSORB;
                end
            end
            ST_FULL_LAST: begin
                if (f_ack) begin
                    buffer_d  = '0;
                    wordCnt_d = '0;
                    done_d    = 1'b1;
                    state_d   = ST_ABSORB;
                end
            end
            default: state_d = ST_ABSORB;
        endcase

        if (slotWrite) begin
            slotWe[wordCnt_q] = 1'b1;
        end
        for (int j = 0; j < NW; j++) begin
            if (slotWe[j]) begin
                buffer_d[R-1-LANE_W*j -: LANE_W] = wrPad ? padWord : in;
            end
        end
        // The closing 0x80 always lives in the top byte of the last slot
        if (wrPad) begin
            buffer_d[LANE_W-1 -: 8] = buffer_d[LANE_W-1 -: 8] | 8'h80;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= ST_ABSORB;
            wordCnt_q    <= '0;
            buffer_q     <= '0;
            padPending_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wordCnt_q    <= wordCnt_d;
            buffer_q     <= buffer_d;
            padPending_q <= padPending_d;
            done_q       <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (resetn && in_valid && in_ready) begin
            assert (in_last || (in_bytes != 4'd0));
        end
    end

    assign in_ready  = (state_q == ST_ABSORB);
    assign out_ready = (state_q == ST_FULL) || (state_q == ST_FULL_LAST);
    assign out       = buffer_q;
    assign done      = done_q;

endmodule

// File: tb/tb_sponge_padder.sv
// Bench for sponge_padder: a byte-level SHA-3/SHAKE padding model predicts every
// rate block for a SHAKE (0x1F) and a SHA3 (0x06) instance driven in lockstep.
module tb_sponge_padder;

    localparam int R  = 1344;
    localparam int RB = R / 8;

    logic          clk = 1'b0;
    logic          resetn;
    logic [63:0]   inData;
    logic [3:0]    inBytes;
    logic          inValid;
    logic          inLast;
    logic          fAck;
    logic          inReadyA, outReadyA, doneA;
    logic          inReadyB, outReadyB, doneB;
    logic [R-1:0]  outA, outB;

    int            checks = 0;
    int            errors = 0;
    int            ackMode = 1;
    logic          pendingDone = 1'b0;
    logic [R-1:0]  expA[$];
    logic [R-1:0]  expB[$];
    bit            finalQ[$];
    logic [7:0]    msgQ[$];
    logic [R-1:0]  litEmpty;

    always #5 clk = ~clk;

    sponge_padder #(.R(R), .DSEP(8'h1F)) dutShake (
        .clk(clk), .resetn(resetn), .in(inData), .in_bytes(inBytes),
        .in_valid(inValid), .in_last(inLast), .in_ready(inReadyA),
        .out(outA), .out_ready(outReadyA), .f_ack(fAck), .done(doneA)
    );

    sponge_padder #(.R(R), .DSEP(8'h06)) dutSha3 (
        .clk(clk), .resetn(resetn), .in(inData), .in_bytes(inBytes),
        .in_valid(inValid), .in_last(inLast), .in_ready(inReadyB),
        .out(outB), .out_ready(outReadyB), .f_ack(fAck), .done(doneB)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkBlock(input string name, input logic [R-1:0] act, input logic [R-1:0] exp);
        int bad = -1;
        checks++;
        for (int j = R / 64 - 1; j >= 0; j--) begin
            if (act[64*j +: 64] !== exp[64*j +: 64]) bad = j;
        end
        if (bad >= 0) begin
            errors++;
            $display("[TB] FAIL %s: slot %0d got %h expected %h", name, R / 64 - 1 - bad,
                     act[64*bad +: 64], exp[64*bad +: 64]);
        end
    endtask

    // Padded message byte idx: M || dsep || 0* with 0x80 OR-ed into the very last byte
    function automatic logic [7:0] modelByte(input int idx, input int len, input logic [7:0] dsep, input int total);
        logic [7:0] v = 8'h00;
        if (idx < len) v = msgQ[idx];
        else if (idx == len) v = dsep;
        if (idx == total * RB - 1) v = v | 8'h80;
        return v;
    endfunction

    task automatic pushExpected(input int len);
        int nblk = len / RB + 1;
        logic [R-1:0] blkA, blkB;
        for (int b = 0; b < nblk; b++) begin
            blkA = '0;
            blkB = '0;
            for (int p = 0; p < RB; p++) begin
                blkA[R - 64 - 64 * (p / 8) + 8 * (p % 8) +: 8] = modelByte(b * RB + p, len, 8'h1F, nblk);
                blkB[R - 64 - 64 * (p / 8) + 8 * (p % 8) +: 8] = modelByte(b * RB + p, len, 8'h06, nblk);
            end
            expA.push_back(blkA);
            expB.push_back(blkB);
            finalQ.push_back(b == nblk - 1);
        end
    endtask

    task automatic fillPattern(input int len, input int seed);
        msgQ.delete();
        for (int i = 0; i < len; i++) msgQ.push_back(8'(i * 7 + seed));
    endtask

    task automatic applyStimulus(input logic [63:0] w, input logic [3:0] nb, input logic last);
        int waited = 0;
        bit accepted = 1'b0;
        inData  = w;
        inBytes = nb;
        inLast  = last;
        inValid = 1'b1;
        while (!accepted && waited < 300) begin
            @(negedge clk);
            if (inReadyA) accepted = 1'b1;
            else waited++;
        end
        if (!accepted) begin
            checks++;
            errors++;
            $display("[TB] FAIL wordAccept: got timeout expected in_ready");
        end else begin
            @(posedge clk);
            #1;
        end
        inValid = 1'b0;
        inLast  = 1'b0;
    endtask

    task automatic sendMessage(input int len);
        int nfull = len / 8;
        int rem   = len % 8;
        logic [63:0] w;
        pushExpected(len);
        for (int i = 0; i < nfull; i++) begin
            for (int k = 0; k < 8; k++) w[8*k +: 8] = msgQ[8 * i + k];
            applyStimulus(w, 4'd8, (rem == 0) && (i == nfull - 1));
        end
        if (rem != 0 || len == 0) begin
            w = {8{8'hA5}};
            for (int k = 0; k < rem; k++) w[8*k +: 8] = msgQ[8 * nfull + k];
            applyStimulus(w, 4'(rem), 1'b1);
        end
    endtask

    task automatic waitReady();
        int n = 0;
        while (!outReadyA && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput("waitReady", 64'(outReadyA), 64'd1);
    endtask

    task automatic waitDrain();
        int n = 0;
        while (expA.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drained", 64'(expA.size()), 64'd0);
        expA.delete();
        expB.delete();
        finalQ.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Acknowledge policy: 0 holds off, 1 acks as soon as a block is shown, 2 acks every cycle
    initial begin
        fAck = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ackMode)
                0:       fAck = 1'b0;
                2:       fAck = 1'b1;
                default: fAck = outReadyA;
            endcase
        end
    end

    always @(negedge clk) begin
        if (!resetn) begin
            pendingDone = 1'b0;
        end else begin
            checkOutput("done", 64'(doneA), 64'(pendingDone));
            checkOutput("pairSync", {61'd0, inReadyB, outReadyB, doneB}, {61'd0, inReadyA, outReadyA, doneA});
            pendingDone = 1'b0;
            if (outReadyA) begin
                checkOutput("inReadyWhileFull", 64'(inReadyA), 64'd0);
                if (expA.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedBlock: got out_ready=1 expected no block");
                end else begin
                    checkBlock("blockShake", outA, expA[0]);
                    checkBlock("blockSha3", outB, expB[0]);
                    if (fAck) begin
                        pendingDone = finalQ[0];
                        void'(expA.pop_front());
                        void'(expB.pop_front());
                        void'(finalQ.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lens[4] = '{8, 100, 335, 336};
        logic [63:0] w;
        resetn  = 1'b0;
        inData  = '0;
        inBytes = '0;
        inValid = 1'b0;
        inLast  = 1'b0;
        litEmpty = '0;
        litEmpty[R-64 +: 8] = 8'h1F;
        litEmpty[63:56]     = 8'h80;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;

        @(negedge clk);
        checkOutput("resetInReady", 64'(inReadyA), 64'd1);
        checkOutput("resetOutReady", 64'(outReadyA), 64'd0);
        checkOutput("resetDone", 64'(doneA), 64'd0);
        checkBlock("resetBuffer", outA, '0);
        @(posedge clk);
        #1;

        // Empty message
        ackMode = 0;
        fillPattern(0, 0);
        sendMessage(0);
        checkOutput("emptyLatency", 64'(outReadyA), 64'd1);
        checkBlock("modelEmpty", expA[0], litEmpty);
        checkBlock("emptyLiteral", outA, litEmpty);
        checkOutput("emptySha3Byte0", 64'(outB[R-64 +: 8]), 64'h06);
        ackMode = 1;
        waitDrain();

        // Three-byte message 0xABCDEF
        ackMode = 0;
        msgQ = '{8'hEF, 8'hCD, 8'hAB};
        sendMessage(3);
        checkOutput("shortLatency", 64'(outReadyA), 64'd1);
        checkOutput("sha3Word0", outB[R-1 -: 64], 64'h0000_0000_06AB_CDEF);
        checkOutput("shakeWord0", outA[R-1 -: 64], 64'h0000_0000_1FAB_CDEF);
        checkOutput("sha3FinalSlot", outB[63:0], 64'h8000_0000_0000_0000);
        ackMode = 1;
        waitDrain();

        // 167 bytes: pad byte and final bit share the last byte
        ackMode = 0;
        fillPattern(167, 3);
        sendMessage(167);
        waitReady();
        checkOutput("model9F", 64'(expA[0][63:56]), 64'h9F);
        checkOutput("pad9F", 64'(outA[63:56]), 64'h9F);
        checkOutput("pad86", 64'(outB[63:56]), 64'h86);
        ackMode = 1;
        waitDrain();

        // 168 bytes: raw block then a pad-only block
        ackMode = 0;
        fillPattern(168, 11);
        sendMessage(168);
        waitReady();
        checkOutput("exactBlocks", 64'(expA.size()), 64'd2);
        checkBlock("modelPadOnly", expA[1], litEmpty);
        checkOutput("exactWord0", outA[R-1 -: 64], {msgQ[7], msgQ[6], msgQ[5], msgQ[4], msgQ[3], msgQ[2], msgQ[1], msgQ[0]});
        ackMode = 1;
        waitDrain();

        // Full last word with space left takes an extra PAD cycle
        ackMode = 0;
        fillPattern(16, 21);
        sendMessage(16);
        checkOutput("fullLastLatency1", 64'(outReadyA), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("fullLastLatency2", 64'(outReadyA), 64'd1);
        ackMode = 1;
        waitDrain();

        // f_ack held high throughout, including while absorbing
        ackMode = 2;
        fillPattern(20, 9);
        sendMessage(20);
        waitDrain();
        ackMode = 1;
        repeat (2) @(posedge clk);
        #1;

        // Backpressure: block held 20 cycles while the next word waits
        ackMode = 0;
        fillPattern(179, 5);
        fork
            sendMessage(179);
            begin
                waitReady();
                repeat (20) @(posedge clk);
                #1;
                ackMode = 1;
            end
        join
        waitDrain();

        // Reset after five words drops the partial block
        fillPattern(40, 1);
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < 8; k++) w[8*k +: 8] = msgQ[8 * i + k];
            applyStimulus(w, 4'd8, 1'b0);
        end
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        checkOutput("midResetOutReady", 64'(outReadyA), 64'd0);
        checkOutput("midResetInReady", 64'(inReadyA), 64'd1);
        checkBlock("midResetBuffer", outA, '0);
        msgQ = '{8'h5A};
        sendMessage(1);
        waitDrain();

        foreach (lens[i]) begin
            fillPattern(lens[i], lens[i]);
            sendMessage(lens[i]);
            waitDrain();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
